apb_requester: RTL
==================

// Module: apb_requester
// PURPOSE
//  APB manager (requester) bridging a local valid/ready command port onto an APB bus.
//  Accepts one read/write command at a time and drives the SETUP and ACCESS phases.
//  Decodes the upper address bits into one-hot PSEL, waits on PREADY with an optional
//  timeout, and returns read data and status on a valid/ready response port.
//  Sits between a local master (CPU/DMA/test driver) and the APB completers.
// PARAMETERS
//  ADDR_W   8    APB address width; PADDR carries the full latched address
//  NUM_SLV  4    number of completers (1..16); SEL_W = max(1,$clog2(NUM_SLV))
//  TIMEOUT  16   max ACCESS cycles without PREADY before abort; 0 = wait forever
// PORTS
//  PCLK       in   1        bus clock, all logic on rising edge
//  PRESETn    in   1        asynchronous, active-low reset
//  req_valid  in   1        command valid
//  req_ready  out  1        command accepted when req_valid & req_ready
//  req_write  in   1        1 = write, 0 = read
//  req_addr   in   ADDR_W   byte address; [ADDR_W-1 -: SEL_W] = completer index
//  req_wdata  in   32       write data
//  rsp_valid  out  1        response valid, held until rsp_ready
//  rsp_ready  in   1        response consumed
//  rsp_rdata  out  32       read data (0 for writes and errors)
//  rsp_err    out  1        1 = timeout or decode miss
//  PADDR      out  ADDR_W   APB address
//  PWRITE     out  1        APB direction
//  PSEL       out  NUM_SLV  one-hot completer select
//  PENABLE    out  1        APB access phase
//  PWDATA     out  32       APB write data
//  PRDATA     in   32       APB read data
//  PREADY     in   1        APB ready; only logic 1 completes, 0/Z/X = wait
// BEHAVIOUR
//  Reset (PRESETn=0, async): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA,
//   rsp_valid, rsp_err, rsp_rdata all 0. req_ready = 1 on the first cycle after release.
//  FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. Only one command is outstanding.
//  IDLE: req_ready=1. On req_valid: latch write/addr/wdata into PWRITE/PADDR/PWDATA.
//   Valid index (< NUM_SLV): go to SETUP.
//   Invalid index: no bus cycle, PSEL stays 0; go to RESP with rsp_err=1, rdata=0.
//  SETUP (exactly 1 cycle): PSEL[idx]=1, PENABLE=0; then go to ACCESS.
//  ACCESS: PSEL[idx]=1, PENABLE=1. PADDR, PWRITE and PWDATA stay stable.
//   PREADY==1 sampled at an edge: capture PRDATA into rsp_rdata (reads; 0 for writes);
//   rsp_err=0; PSEL=0 and PENABLE=0 from the next cycle; go to RESP.
//   PREADY not 1: wait count increments.
//   Count reaches TIMEOUT (TIMEOUT>0): abort; PSEL and PENABLE drop; rsp_err=1,
//   rdata=0; go to RESP. The count clears on entry to SETUP.
//  RESP: rsp_valid=1; rsp_rdata and rsp_err stable. On rsp_ready: go to IDLE and
//   clear rsp_valid. req_ready=0 throughout.
//  Latency: command accepted at edge E0 -> SETUP in cycle E0..E1 -> ACCESS from E1.
//   PREADY=1 at edge E1+k (k>=1) -> rsp_valid from edge E1+k.
//   Zero-wait completer: rsp_valid two cycles after acceptance.
//  Between transfers PADDR, PWRITE and PWDATA hold their last value; PSEL and
//   PENABLE are 0 in IDLE and RESP. PENABLE is never 1 while PSEL is 0.
//  req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
//  Reset mid-transfer: bus signals drop to 0 immediately (async) and the pending
//   response is discarded.
// TESTING
//  1 Write 0xDEADBEEF to addr 0x04 (slot 0, 4-reg completer) -> PSEL=0001 for 2 cycles,
//    PENABLE 1 cycle after PSEL, PWDATA stable; rsp_err=0, rsp_rdata=0.
//  2 Read addr 0x04 after test 1 -> rsp_rdata=0xDEADBEEF, rsp_err=0. Completer inserts
//    1 wait state: rsp_valid 3 cycles after acceptance.
//  3 PREADY held 0, TIMEOUT=16 -> abort after 16 ACCESS cycles; PSEL=0; rsp_err=1,
//    rsp_rdata=0.
//  4 NUM_SLV=3, read addr 0xC0 (index 3) -> PSEL never asserts; rsp_valid next cycle
//    with rsp_err=1.
//  5 rsp_ready low for 5 cycles with req_valid held high -> rsp_valid and rsp_rdata
//    stable, req_ready=0; second command starts SETUP only after the RESP handshake.
//  6 PRESETn low during ACCESS -> PSEL, PENABLE and rsp_valid 0 asynchronously;
//    after release a new write completes normally.

Source files
------------

// File: rtl/apb_requester.sv
// APB requester: turns one local valid/ready command at a time into an APB
// SETUP/ACCESS transfer and returns read data and status on a response port.
module apb_requester #(
  parameter int ADDR_W  = 8,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [ADDR_W-1:0]  PADDR,
  output logic               PWRITE,
  output logic [NUM_SLV-1:0] PSEL,
  output logic               PENABLE,
  output logic [31:0]        PWDATA,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_paddr;
  logic               r_pwrite;
  logic [NUM_SLV-1:0] r_psel;
  logic               r_penable;
  logic [31:0]        r_pwdata;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;

  logic [SEL_W-1:0]   w_idx;
  logic               w_hit;
  logic [NUM_SLV-1:0] w_onehot;
  logic               w_timeout;
  logic               w_ready;

  assign w_idx     = req_addr[ADDR_W-1 -: SEL_W];
  assign w_hit     = (32'(w_idx) < 32'(NUM_SLV));
  assign w_timeout = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  // X or Z on PREADY must read as "wait", so only an explicit 1 completes
  assign w_ready   = (PREADY == 1'b1);

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (w_idx == SEL_W'(i)) w_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_pwrite <= req_write;
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
            if (w_hit) begin
              r_psel  <= w_onehot;
              r_cnt   <= '0;
              r_state <= S_SETUP;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_ready) begin
            r_rsp_rdata <= r_pwrite ? 32'h0 : PRDATA;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWDATA    = r_pwdata;

endmodule
